zebra_multi_column_detector: RTL and testbench

Parametrised successor to the single-column zebra detector. It taps the filtered greyscale pixel stream and runs NUM_COLS independent vertical stripe analysers in parallel on evenly spaced columns. Gray gaps inside a stripe are tolerated up to a set length, and the white/black thresholds are programmable at runtime. Once per frame it emits a single result beat carrying a majority-vote decision, a per-column hit mask and the vote count, over its own valid/ready handshake.

---
 rtl/zebra_multi_column_detector.sv | 230 +++++++++++++++++++++++
 tb/tb_zebra_multi_column_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/zebra_multi_column_detector.sv
// Multi-column vertical zebra-stripe detector: NUM_COLS parallel stripe analysers on a
// raster pixel tap, with a once-per-frame majority-vote result over valid/ready.
module zebra_multi_column_detector #(
    parameter int unsigned IMG_WIDTH         = 320,
    parameter int unsigned IMG_HEIGHT        = 240,
    parameter int unsigned W                 = 8,
    parameter int unsigned NUM_COLS          = 4,
    parameter int unsigned COL_START         = 40,
    parameter int unsigned COL_STEP          = 80,
    parameter int unsigned MIN_STRIPE_HEIGHT = 4,
    parameter int unsigned MIN_ALTERNATIONS  = 6,
    parameter int unsigned MAX_GRAY_RUN      = 2,
    parameter int unsigned MIN_VOTES         = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [W-1:0]                      white_thresh,
    input  logic [W-1:0]                      black_thresh,
    input  logic                              x_valid,
    output logic                              x_ready,
    input  logic [W-1:0]                      x_data,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_detected,
    output logic [NUM_COLS-1:0]               res_col_mask,
    output logic [$clog2(NUM_COLS+1)-1:0]     res_votes,
    output logic                              overrun
);

    localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned RW = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned GW = $clog2(MAX_GRAY_RUN + 2);
    localparam int unsigned AW = $clog2(MIN_ALTERNATIONS + 1);
    localparam int unsigned VW = $clog2(NUM_COLS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WHITE,
        S_BLACK
    } col_state_e;

    typedef struct packed {
        logic [AW-1:0] alt;
        logic          last_white;
        logic          have_last;
    } hist_t;

    // A run only counts as a stripe if long enough; alternation needs a colour change.
    function automatic hist_t close_run(input hist_t h, input logic [RW-1:0] run,
                                        input logic white);
        hist_t r;
        r = h;
        if (run >= RW'(MIN_STRIPE_HEIGHT)) begin
            if ((!h.have_last || (h.last_white != white)) &&
                (h.alt < AW'(MIN_ALTERNATIONS))) begin
                r.alt = h.alt + 1'b1;
            end
            r.last_white = white;
            r.have_last  = 1'b1;
        end
        return r;
    endfunction

    logic [XW-1:0]       x_pos_q;
    logic [YW-1:0]       y_pos_q;
    logic [W-1:0]        wt_q;
    logic [W-1:0]        bt_q;
    logic                res_valid_q;
    logic                res_detected_q;
    logic [NUM_COLS-1:0] res_mask_q;
    logic [VW-1:0]       res_votes_q;
    logic                overrun_q;

    logic                accept;
    logic                first_pos;
    logic                at_first;
    logic                last_row;
    logic                last_px;
    logic [W-1:0]        wt_eff;
    logic [W-1:0]        bt_eff;
    logic                px_white;
    logic                px_black;
    logic [NUM_COLS-1:0] hit_d;
    logic [VW-1:0]       votes_d;

    assign x_ready   = 1'b1;
    assign accept    = x_valid;
    assign first_pos = (x_pos_q == '0) && (y_pos_q == '0);
    assign at_first  = accept && first_pos;
    assign last_row  = (y_pos_q == YW'(IMG_HEIGHT - 1));
    assign last_px   = accept && last_row && (x_pos_q == XW'(IMG_WIDTH - 1));

    // Pixel (0,0) classifies with the live thresholds, which are latched for the frame.
    assign wt_eff   = first_pos ? white_thresh : wt_q;
    assign bt_eff   = first_pos ? black_thresh : bt_q;
    assign px_white = (x_data >= wt_eff);
    assign px_black = !px_white && (x_data <= bt_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            wt_q    <= '0;
            bt_q    <= '0;
        end else if (accept) begin
            if (first_pos) begin
                wt_q <= white_thresh;
                bt_q <= black_thresh;
            end
            if (x_pos_q == XW'(IMG_WIDTH - 1)) begin
                x_pos_q <= '0;
                y_pos_q <= last_row ? '0 : y_pos_q + 1'b1;
            end else begin
                x_pos_q <= x_pos_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        localparam int unsigned COL = COL_START + k * COL_STEP;

        col_state_e    st_q, st_d;
        logic [RW-1:0] run_q, run_d;
        logic [GW-1:0] gray_q, gray_d;
        hist_t         hist_q, hist_d;
        logic          here;

        assign here = accept && (x_pos_q == XW'(COL));

        always_comb begin
            st_d   = st_q;
            run_d  = run_q;
            gray_d = gray_q;
            hist_d = hist_q;
            if (at_first) begin
                st_d   = S_IDLE;
                run_d  = '0;
                gray_d = '0;
                hist_d = '0;
            end
            if (here) begin
                case (st_d)
                    S_IDLE: begin
                        if (px_white || px_black) begin
                            st_d   = px_white ? S_WHITE : S_BLACK;
                            run_d  = RW'(1);
                            gray_d = '0;
                        end
                    end
                    default: begin
                        if (!px_white && !px_black) begin
                            if (gray_d == GW'(MAX_GRAY_RUN)) begin
                                st_d   = S_IDLE;
                                run_d  = '0;
                                gray_d = '0;
                            end else begin
                                gray_d = gray_d + 1'b1;
                            end
                        end else if ((st_d == S_WHITE) == px_white) begin
                            if (run_d != '1) begin
                                run_d = run_d + 1'b1;
                            end
                            gray_d = '0;
                        end else begin
                            hist_d = close_run(hist_d, run_d, st_d == S_WHITE);
                            st_d   = px_white ? S_WHITE : S_BLACK;
                            run_d  = RW'(1);
                            gray_d = '0;
                        end
                    end
                endcase
                // Bottom row ends the frame for this column, so the open run closes here too.
                if (last_row && (st_d != S_IDLE)) begin
                    hist_d = close_run(hist_d, run_d, st_d == S_WHITE);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= S_IDLE;
                run_q  <= '0;
                gray_q <= '0;
                hist_q <= '0;
            end else begin
                st_q   <= st_d;
                run_q  <= run_d;
                gray_q <= gray_d;
                hist_q <= hist_d;
            end
        end

        assign hit_d[k] = (hist_d.alt >= AW'(MIN_ALTERNATIONS));
    end

    always_comb begin
        votes_d = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            votes_d = votes_d + VW'(hit_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q    <= 1'b0;
            res_detected_q <= 1'b0;
            res_mask_q     <= '0;
            res_votes_q    <= '0;
            overrun_q      <= 1'b0;
        end else if (last_px) begin
            res_valid_q    <= 1'b1;
            res_detected_q <= (votes_d >= VW'(MIN_VOTES));
            res_mask_q     <= hit_d;
            res_votes_q    <= votes_d;
            if (res_valid_q && !res_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_detected = res_detected_q;
    assign res_col_mask = res_mask_q;
    assign res_votes    = res_votes_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_zebra_multi_column_detector.sv
// Directed bench for zebra_multi_column_detector on a reduced 8x48 frame, columns 1,3,5,7.
module tb_zebra_multi_column_detector;

    localparam int TW   = 8;
    localparam int TH   = 48;
    localparam int NPIX = TW * TH;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] white_thresh;
    logic [7:0] black_thresh;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] x_data;
    logic       res_valid;
    logic       res_ready;
    logic       res_detected;
    logic [3:0] res_col_mask;
    logic [2:0] res_votes;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    int         cfg_bh;
    int         cfg_gap;
    logic [7:0] cfg_wv;
    logic [3:0] cfg_cols;
    logic       pre_last_valid;

    zebra_multi_column_detector #(
        .IMG_WIDTH        (TW),
        .IMG_HEIGHT       (TH),
        .W                (8),
        .NUM_COLS         (4),
        .COL_START        (1),
        .COL_STEP         (2),
        .MIN_STRIPE_HEIGHT(4),
        .MIN_ALTERNATIONS (6),
        .MAX_GRAY_RUN     (2),
        .MIN_VOTES        (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .white_thresh(white_thresh),
        .black_thresh(black_thresh),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_detected(res_detected),
        .res_col_mask(res_col_mask),
        .res_votes   (res_votes),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int x, input int y);
        logic [7:0] v;
        int r;
        v = 8'd128;
        if ((x % 2 == 1) && cfg_cols[(x - 1) / 2]) begin
            r = y % cfg_bh;
            if (cfg_gap > 0 && r >= 2 && r < 2 + cfg_gap) v = 8'd128;
            else if ((y / cfg_bh) % 2 == 0) v = cfg_wv;
            else v = 8'd0;
        end
        return v;
    endfunction

    task automatic send_frame(input int npix, input bit gaps, input int thr_row,
                              input logic [7:0] thr_new);
        int idx = 0;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (idx < npix) begin
                    if (gaps && (idx % 37 == 5)) begin
                        x_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    if (y == thr_row && x == 0) white_thresh = thr_new;
                    if (idx == NPIX - 1) pre_last_valid = res_valid;
                    x_valid = 1'b1;
                    x_data  = pix(x, y);
                    @(posedge clk); #1;
                end
                idx++;
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] exp_mask);
        logic [2:0] exp_votes;
        exp_votes = 3'($countones(exp_mask));
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_mask"}, res_col_mask, exp_mask);
        check({tag, "_votes"}, res_votes, exp_votes);
        check({tag, "_detected"}, res_detected, exp_votes >= 3'd3);
    endtask

    initial begin
        rst_n        = 1'b0;
        white_thresh = 8'd200;
        black_thresh = 8'd50;
        x_valid      = 1'b0;
        x_data       = '0;
        res_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 1'b0);
        check("rst_x_ready", x_ready, 1'b1);
        check("rst_detected", res_detected, 1'b0);
        check("rst_mask", res_col_mask, 4'b0000);
        check("rst_votes", res_votes, 3'd0);
        check("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Six 8-row bands: sixth stripe closes at the bottom row (column 7 on the final pixel).
        cfg_bh = 8; cfg_gap = 0; cfg_wv = 8'd255; cfg_cols = 4'b1111;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check("f1_pre_last_valid", pre_last_valid, 1'b0);
        check_frame("f1", 4'b1111);

        cfg_cols = 4'b0011;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f2_two_cols", 4'b0011);

        cfg_bh = 3; cfg_cols = 4'b1111;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f3_short", 4'b0000);

        cfg_bh = 8; cfg_gap = 1;
        send_frame(NPIX, 1'b1, -1, 8'd0);
        check_frame("f4_gray1_gaps", 4'b1111);

        cfg_gap = 3;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f5_gray3", 4'b0000);

        // 190 is gray under the latched 200; a live 180 from row 1 would give six stripes.
        cfg_gap = 0; cfg_wv = 8'd190;
        send_frame(NPIX, 1'b0, 1, 8'd180);
        check_frame("f6_thr_latched", 4'b0000);
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f7_thr_next", 4'b1111);
        @(posedge clk); #1;
        check("f7_valid_drop", res_valid, 1'b0);
        check("f7_no_overrun", overrun, 1'b0);

        res_ready = 1'b0;
        cfg_wv = 8'd255; cfg_bh = 3;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f8_first", 4'b0000);
        check("f8_overrun", overrun, 1'b0);
        cfg_bh = 8;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check_frame("f9_overwrite", 4'b1111);
        check("f9_overrun", overrun, 1'b1);
        @(posedge clk); #1;
        check("f9_hold_valid", res_valid, 1'b1);
        check("f9_hold_mask", res_col_mask, 4'b1111);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("f9_accept_drop", res_valid, 1'b0);
        check("f9_overrun_sticky", overrun, 1'b1);
        @(posedge clk); #1;
        check("f9_stays_low", res_valid, 1'b0);

        // Abort a frame at row 20 with a pattern that would misalign positions.
        cfg_bh = 3;
        send_frame(20 * TW + 3, 1'b0, -1, 8'd0);
        rst_n = 1'b0;
        #1;
        check("rst2_valid", res_valid, 1'b0);
        check("rst2_overrun", overrun, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cfg_bh = 8;
        send_frame(NPIX, 1'b0, -1, 8'd0);
        check("f10_pre_last_valid", pre_last_valid, 1'b0);
        check_frame("f10_after_reset", 4'b1111);
        check("f10_overrun", overrun, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
